// File: rtl/circuito_pwm_pkg.sv
// Shared constants and helpers for the servo PWM generator.
// Latency: n/a (package only).
// Backpressure: n/a.
package circuito_pwm_pkg;

  // Default period: 20 ms at 50 MHz.
  localparam int unsigned PERIODO_PADRAO = 32'd1000000;

  // Default high times, 20 deg to 160 deg in 20 deg steps at 50 MHz.
  localparam int unsigned LARGURA_000_PADRAO = 32'd55556;
  localparam int unsigned LARGURA_001_PADRAO = 32'd61111;
  localparam int unsigned LARGURA_010_PADRAO = 32'd66667;
  localparam int unsigned LARGURA_011_PADRAO = 32'd72222;
  localparam int unsigned LARGURA_100_PADRAO = 32'd77778;
  localparam int unsigned LARGURA_101_PADRAO = 32'd83333;
  localparam int unsigned LARGURA_110_PADRAO = 32'd88889;
  localparam int unsigned LARGURA_111_PADRAO = 32'd94444;

  // Counter width for a modulo-m counter, never narrower than one bit.
  function automatic int unsigned calc_cw(input int unsigned m);
    int unsigned w;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/circuito_pwm_contador_m.sv
// Modulo-M free-running up counter with a terminal-count flag.
// Latency: count advances every clock; fim is combinational on the current count.
// Backpressure: none, the counter never stalls.
module contador_m
  import circuito_pwm_pkg::*;
#(
  parameter int unsigned M = PERIODO_PADRAO,
  parameter int unsigned W = calc_cw(M)
) (
  input  logic         clock,
  input  logic         reset,
  output logic [W-1:0] count,
  output logic         fim
);

  // Terminal count: the next clock returns the counter to zero.
  assign fim = (count == W'(M - 1));

  // Count up, wrapping from M-1 back to 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (fim) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/circuito_pwm.sv
// Servo PWM: one pulse per conf_periodo clocks, width chosen from eight values by largura.
// Latency: pwm is registered, rising one clock after the counter reaches zero.
// Backpressure: none; largura is quasi-static. Macro CIRCUITO_PWM_SYNC_UPDATE_EN
//   selects width update at the period boundary; undefined gives pass-through.
module circuito_pwm
  import circuito_pwm_pkg::*;
#(
  parameter int unsigned conf_periodo = PERIODO_PADRAO,
  parameter int unsigned largura_000  = LARGURA_000_PADRAO,
  parameter int unsigned largura_001  = LARGURA_001_PADRAO,
  parameter int unsigned largura_010  = LARGURA_010_PADRAO,
  parameter int unsigned largura_011  = LARGURA_011_PADRAO,
  parameter int unsigned largura_100  = LARGURA_100_PADRAO,
  parameter int unsigned largura_101  = LARGURA_101_PADRAO,
  parameter int unsigned largura_110  = LARGURA_110_PADRAO,
  parameter int unsigned largura_111  = LARGURA_111_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] largura,
  output logic       pwm
);

  localparam int unsigned CW = calc_cw(conf_periodo);

  logic [CW-1:0] contagem;
  logic          fim;
  logic [31:0]   largura_mux;
  logic [31:0]   largura_ativa;

  contador_m #(
    .M (conf_periodo),
    .W (CW)
  ) u_contador (
    .clock (clock),
    .reset (reset),
    .count (contagem),
    .fim   (fim)
  );

  // Select the high time for the requested position.
  always_comb begin
    largura_mux = largura_000;
    case (largura)
      3'b000:  largura_mux = largura_000;
      3'b001:  largura_mux = largura_001;
      3'b010:  largura_mux = largura_010;
      3'b011:  largura_mux = largura_011;
      3'b100:  largura_mux = largura_100;
      3'b101:  largura_mux = largura_101;
      3'b110:  largura_mux = largura_110;
      default: largura_mux = largura_111;
    endcase
  end

`ifdef CIRCUITO_PWM_SYNC_UPDATE_EN
  // Latch the new width only on the wrap so a pulse in progress is never altered.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      largura_ativa <= largura_000;
    end else if (fim) begin
      largura_ativa <= largura_mux;
    end
  end
`else
  // Width follows the selector directly; a change can reshape the current pulse.
  assign largura_ativa = largura_mux;
`endif

  // High while the count is below the active width; widths >= period keep it high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm <= 1'b0;
    end else begin
      pwm <= (32'(contagem) < largura_ativa);
    end
  end

endmodule

// File: tb/tb_circuito_pwm.sv
module tb_circuito_pwm;

  localparam int unsigned P = 20;
`ifdef CIRCUITO_PWM_SYNC_UPDATE_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic [2:0] largura;
  logic       pwm;

  int          checks;
  int          failures;
  int unsigned cyc;     // clock edges since reset release
  int unsigned per_w;   // width that governs the current period (boundary-update build)

  circuito_pwm #(
    .conf_periodo (20),
    .largura_000  (0),
    .largura_001  (1),
    .largura_010  (5),
    .largura_011  (10),
    .largura_100  (19),
    .largura_101  (20),
    .largura_110  (25),
    .largura_111  (3)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .largura (largura),
    .pwm     (pwm)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int unsigned wtab(input logic [2:0] s);
    case (s)
      3'd0: return 0;
      3'd1: return 1;
      3'd2: return 5;
      3'd3: return 10;
      3'd4: return 19;
      3'd5: return 20;
      3'd6: return 25;
      default: return 3;
    endcase
  endfunction

  // Reference: pwm after an edge is high iff the phase within the period is below
  // the width in force. The boundary build fixes the width per period from the
  // selector seen at the end of the previous period; pass-through uses the live selector.
  task automatic tick(input logic [2:0] l, output logic e);
    int unsigned ph;
    int unsigned w;
    largura = l;
    ph = cyc % P;
    w  = SYNC ? per_w : wtab(l);
    e  = (ph < w);
    if (ph == P - 1) per_w = wtab(l);
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic release_reset();
    reset = 1'b1;
    cyc   = 0;
    per_w = wtab(3'd0);
  endtask

  task automatic pulse_reset();
    #3 reset = 1'b0;
    @(posedge clock);
    #1;
    release_reset();
  endtask

  task automatic test_reset();
    logic e;
    int   highs;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    checks++;
    if (pwm !== 1'b0) begin failures++; $display("FAIL reset_init pwm=%b expected=0", pwm); end
    @(posedge clock);
    #1;
    checks++;
    if (pwm !== 1'b0) begin failures++; $display("FAIL reset_hold pwm=%b expected=0", pwm); end
    release_reset();
    for (int i = 0; i < 25; i++) begin
      tick(3'd5, e);
      checks++;
      if (pwm !== e) begin failures++; $display("FAIL reset_pre cyc=%0d pwm=%b expected=%b", cyc, pwm, e); end
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (pwm !== 1'b0) begin failures++; $display("FAIL reset_async pwm=%b expected=0", pwm); end
    @(posedge clock);
    #1;
    checks++;
    if (pwm !== 1'b0) begin failures++; $display("FAIL reset_mid_hold pwm=%b expected=0", pwm); end
    release_reset();
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      tick(3'd2, e);
      if (pwm === 1'b1) highs++;
      checks++;
      if (pwm !== e) begin failures++; $display("FAIL reset_post cyc=%0d pwm=%b expected=%b", cyc, pwm, e); end
    end
    checks++;
    if (highs !== (SYNC ? 0 : 5)) begin
      failures++; $display("FAIL reset_first_period highs=%0d expected=%0d", highs, SYNC ? 0 : 5);
    end
  endtask

  task automatic test_width1();
    logic e;
    int   highs;
    pulse_reset();
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      tick(3'd1, e);
      checks++;
      if (pwm !== e) begin failures++; $display("FAIL width1 cyc=%0d pwm=%b expected=%b", cyc, pwm, e); end
      if (pwm === 1'b1) begin
        highs++;
        checks++;
        if (((cyc - 1) % P) !== 0) begin
          failures++; $display("FAIL width1_edge phase=%0d expected=0", (cyc - 1) % P);
        end
      end
    end
    checks++;
    if (highs !== (SYNC ? 2 : 3)) begin
      failures++; $display("FAIL width1_count highs=%0d expected=%0d", highs, SYNC ? 2 : 3);
    end
  endtask

  task automatic test_zero();
    logic e;
    int   highs;
    pulse_reset();
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      tick(3'd0, e);
      if (pwm === 1'b1) highs++;
      checks++;
      if (pwm !== e) begin failures++; $display("FAIL zero cyc=%0d pwm=%b expected=%b", cyc, pwm, e); end
    end
    checks++;
    if (highs !== 0) begin failures++; $display("FAIL zero_count highs=%0d expected=0", highs); end
  endtask

  task automatic test_full();
    logic e;
    int   first_highs;
    int   later_highs;
    pulse_reset();
    first_highs = 0;
    later_highs = 0;
    for (int i = 0; i < 100; i++) begin
      tick((i < 60) ? 3'd5 : 3'd6, e);
      if (pwm === 1'b1) begin
        if (i < 20) first_highs++;
        else        later_highs++;
      end
      checks++;
      if (pwm !== e) begin failures++; $display("FAIL full cyc=%0d pwm=%b expected=%b", cyc, pwm, e); end
    end
    checks++;
    if (first_highs !== (SYNC ? 0 : 20)) begin
      failures++; $display("FAIL full_first highs=%0d expected=%0d", first_highs, SYNC ? 0 : 20);
    end
    checks++;
    if (later_highs !== 80) begin failures++; $display("FAIL full_after_wrap highs=%0d expected=80", later_highs); end
  endtask

  task automatic test_mid_change();
    logic       e;
    logic [2:0] l;
    int         h1;
    int         h2;
    pulse_reset();
    h1 = 0;
    h2 = 0;
    for (int i = 0; i < 60; i++) begin
      l = (i < 23) ? 3'd2 : 3'd3;   // switch at count 3 of the second period
      tick(l, e);
      if (pwm === 1'b1) begin
        if (i >= 20 && i < 40) h1++;
        if (i >= 40)           h2++;
      end
      checks++;
      if (pwm !== e) begin failures++; $display("FAIL mid_change cyc=%0d pwm=%b expected=%b", cyc, pwm, e); end
    end
    checks++;
    if (h1 !== (SYNC ? 5 : 10)) begin failures++; $display("FAIL mid_change_cur highs=%0d expected=%0d", h1, SYNC ? 5 : 10); end
    checks++;
    if (h2 !== 10) begin failures++; $display("FAIL mid_change_next highs=%0d expected=10", h2); end
  endtask

  task automatic test_random();
    logic       e;
    logic [2:0] l;
    int         hold;
    pulse_reset();
    for (int s = 0; s < 40; s++) begin
      l    = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 30);
      if (s == 20) pulse_reset();
      for (int i = 0; i < hold; i++) begin
        tick(l, e);
        checks++;
        if (pwm !== e) begin
          failures++; $display("FAIL random cyc=%0d sel=%0d pwm=%b expected=%b", cyc, l, pwm, e);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    per_w    = 0;
    largura  = 3'd0;
    reset    = 1'b1;
    test_reset();
    test_width1();
    test_zero();
    test_full();
    test_mid_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/circuito_pwm.md
Name: circuito_pwm

Overview:
- Servo-style PWM generator. A free-running period counter produces one pulse per period of `conf_periodo` clocks.
- The pulse width in clocks is selected from eight parameter values by the 3-bit input `largura`.
- Sits between the position-select logic and the servo control pin. With defaults at 50 MHz: 20 ms period, pulse 1.11–1.89 ms (20°–160° in 20° steps).

Parameters:
- conf_periodo, 1000000, period length in clock cycles (≥2).
- largura_000, 55556, high time in clocks for largura=3'b000 (20°).
- largura_001, 61111, high time for 3'b001 (40°).
- largura_010, 66667, high time for 3'b010 (60°).
- largura_011, 72222, high time for 3'b011 (80°).
- largura_100, 77778, high time for 3'b100 (100°).
- largura_101, 83333, high time for 3'b101 (120°).
- largura_110, 88889, high time for 3'b110 (140°).
- largura_111, 94444, high time for 3'b111 (160°).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- largura  in  3  pulse-width select.
- pwm  out  1  PWM output, registered.

Behaviour:
- Single clock domain. Reset is asynchronous and active-low.
- Counter width is CW = max(1, $clog2(conf_periodo)) bits. Width parameters are compared after zero-extension to 32 bits.
- Reset (reset=0): counter=0, pwm=0, active width register=largura_000. These values hold while reset stays low.
- Counter: increments every clock and wraps from conf_periodo-1 to 0. No other wrap point.
- Width mux: combinational 8:1 selection of the largura_xxx value by `largura`.
- Active width register: loads the mux output when the counter wraps, i.e. on the clock where counter==conf_periodo-1, so the new width applies from count 0. Mid-period changes of `largura` never truncate or extend the current pulse (see Optional Feature).
- Output: pwm <= (counter < active_width), registered.
  - pwm is high for exactly active_width consecutive clocks per period.
  - The rising edge occurs one clock after counter becomes 0.
- Boundary cases:
  - active_width=0: pwm constantly low.
  - active_width ≥ conf_periodo: pwm constantly high.
  - largura changes during a period: the current period completes with the old width.
  - Reset mid-period: pwm drops to 0 immediately (asynchronous). After release, counting restarts from 0 using the largura_000 width for the first period.
- No handshake. Input `largura` is treated as quasi-static and is sampled only at the wrap.

Optional Feature:
- Macro CIRCUITO_PWM_SYNC_UPDATE_EN.
- Defined: period-boundary width update exactly as in Behaviour.
- Not defined: the active width follows the mux output every clock (pass-through). A change takes effect on the next clock and may shorten or lengthen the pulse in progress.
- Reset values and everything else are identical in both builds.

Decomposition:
- Shared package circuito_pwm_pkg:
  - default period constant 1000000.
  - eight default width constants.
  - function computing CW.
- One natural sub-module: contador_m (modulo-M up counter with async active-low reset, parameter M, outputs count value and a wrap-flag `fim`).
- Width mux, width register and comparator stay in circuito_pwm.

Test Plan:
- Reset pulse (reset=0 for 1 clock) mid-run -> pwm=0 immediately; counter restarts at 0; first pulse after release lasts largura_000 clocks.
- Defaults, largura=3'b000 held 2 periods -> pwm period 1000000 clocks, high 55556 clocks each period.
- Defaults, sweep largura 000..111, each held ≥2 periods -> high times 55556/61111/66667/72222/77778/83333/88889/94444; period always 1000000.
- Small params (conf_periodo=20, widths 0,1,5,10,19,20,25,3); largura changed at count 3 from 3'b010 to 3'b011 ->
  - with macro: current pulse stays 5 clocks, next pulse 10 clocks.
  - without macro: pulse ends per the new width (10 clocks total).
- Small params, largura=3'b000 (width 0) -> pwm never high. largura=3'b101 and 3'b110 (≥ period) -> pwm constantly high after the first wrap.
- Small params, largura=3'b001 (width 1) -> exactly 1 high clock per 20-clock period; rising edge one clock after counter==0.
